// File: rtl/pcs_sync_pkg.sv
// pcs_sync_pkg: shared encodings, widths and helpers for the multi-lane PCS synchronizer
package pcs_sync_pkg;

   typedef enum logic [4:0] {
      LOSS_OF_SYNC    = 5'b00001,
      COMMA_DETECT    = 5'b00010,
      ACQUIRE_SYNC    = 5'b00100,
      SYNC_ACQUIRED   = 5'b01000,
      SYNC_ACQUIRED_A = 5'b10000
   } state_e;

   localparam logic [6:0] COMMA_P = 7'b0011111;
   localparam logic [6:0] COMMA_M = 7'b1100000;
   localparam int PUDI_W = 10;
   localparam int SUDI_W = 11;

   function automatic logic [3:0] popcnt(input logic [9:0] v);
      popcnt = '0;
      for (int k = 0; k < 10; k++) popcnt = popcnt + {3'b0, v[k]};
   endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// pcs_sync_lane: one-lane code-group classifier and sync FSM; PCS_SYNC_RD_CHECK_EN adds running-disparity checking
module pcs_sync_lane
   import pcs_sync_pkg::*;
#(
   parameter int COMMA_CNT = 3,
   parameter int GOOD_CGS  = 3,
   parameter int LOSS_BAD  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              signal_detect_i,
   input  logic [PUDI_W-1:0] pudi_i,
   output logic              code_sync_status_o,
   output logic              status_d_o,
   output logic [SUDI_W-1:0] sudi_o
);

   localparam int CW = $clog2(COMMA_CNT) + 1;
   localparam int GW = $clog2(GOOD_CGS) + 1;
   localparam int BW = $clog2(LOSS_BAD) + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     comma_q, comma_d;
   logic [GW-1:0]     good_q, good_d, good_inc;
   logic [BW-1:0]     bad_q, bad_d, bad_inc;
   logic              rx_even_q, rx_even_d, status_q, status_d;
   logic [SUDI_W-1:0] sudi_q, sudi_d;
   logic [3:0]        ones, ones_hi, ones_lo;
   logic              is_comma, invalid, is_d, cgbad, rd_bad;

   assign ones     = popcnt(pudi_i);
   assign ones_hi  = popcnt({4'b0, pudi_i[9:4]});
   assign ones_lo  = popcnt({6'b0, pudi_i[3:0]});
   assign is_comma = (pudi_i[9:3] == COMMA_P) || (pudi_i[9:3] == COMMA_M);
   assign invalid  = (ones < 4'd4) || (ones > 4'd6) || (ones_hi < 4'd2) || (ones_hi > 4'd4) ||
                     (ones_lo < 4'd1) || (ones_lo > 4'd3) || rd_bad;
   assign is_d     = !invalid && !is_comma;
   assign cgbad    = invalid || (is_comma && rx_even_q);
   assign bad_inc  = bad_q + BW'(1);
   assign good_inc = good_q + GW'(1);

`ifdef PCS_SYNC_RD_CHECK_EN
   logic rd_q, rd_d;
   assign rd_d   = (ones == 4'd6) ? 1'b1 : (ones == 4'd4) ? 1'b0 : rd_q;
   // a comma while hunting for sync re-establishes disparity instead of being judged by it
   assign rd_bad = !(state_q == LOSS_OF_SYNC && is_comma) &&
                   (((ones == 4'd6) && rd_q) || ((ones == 4'd4) && !rd_q));
   // Running disparity follows every received code group (0 = RD-)
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) rd_q <= 1'b0;
      else         rd_q <= rd_d;
`else
   assign rd_bad = 1'b0;
`endif

   // State, counters, parity and registered outputs advance once per code group
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= LOSS_OF_SYNC;
         comma_q   <= '0;
         good_q    <= '0;
         bad_q     <= '0;
         rx_even_q <= 1'b0;
         status_q  <= 1'b0;
         sudi_q    <= '0;
      end else begin
         state_q   <= state_d;
         comma_q   <= comma_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         rx_even_q <= rx_even_d;
         status_q  <= status_d;
         sudi_q    <= sudi_d;
      end

   // Next-state and counter updates; loss of signal overrides everything
   always_comb begin
      state_d   = state_q;
      comma_d   = comma_q;
      good_d    = good_q;
      bad_d     = bad_q;
      rx_even_d = !rx_even_q;
      if (!signal_detect_i) begin
         state_d = LOSS_OF_SYNC;
         comma_d = '0;
         good_d  = '0;
         bad_d   = '0;
      end else begin
         case (state_q)
            LOSS_OF_SYNC:
               if (is_comma) begin
                  state_d   = COMMA_DETECT;
                  rx_even_d = 1'b1;
                  comma_d   = comma_q + CW'(1);
               end
            COMMA_DETECT: begin
               rx_even_d = 1'b0;
               if (is_d) state_d = (comma_q == CW'(COMMA_CNT)) ? SYNC_ACQUIRED : ACQUIRE_SYNC;
               else begin
                  state_d = LOSS_OF_SYNC;
                  comma_d = '0;
               end
            end
            ACQUIRE_SYNC:
               if (is_comma && !rx_even_q) begin
                  state_d = COMMA_DETECT;
                  comma_d = comma_q + CW'(1);
               end else if (cgbad) begin
                  state_d = LOSS_OF_SYNC;
                  comma_d = '0;
               end
            SYNC_ACQUIRED, SYNC_ACQUIRED_A: begin
               rx_even_d = is_comma || !rx_even_q;
               if (cgbad) begin
                  if (bad_inc == BW'(LOSS_BAD)) begin
                     state_d = LOSS_OF_SYNC;
                     comma_d = '0;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     state_d = SYNC_ACQUIRED;
                     good_d  = '0;
                     bad_d   = bad_inc;
                  end
               end else if (state_q == SYNC_ACQUIRED) begin
                  if (bad_q != '0) begin
                     state_d = SYNC_ACQUIRED_A;
                     good_d  = GW'(1);
                  end
               end else if (good_inc == GW'(GOOD_CGS)) begin
                  state_d = (bad_q == BW'(1)) ? SYNC_ACQUIRED : SYNC_ACQUIRED_A;
                  good_d  = '0;
                  bad_d   = bad_q - BW'(1);
               end else good_d = good_inc;
            end
            default: state_d = LOSS_OF_SYNC;
         endcase
      end
   end

   // Outputs are derived from the next state so SUDI parity matches its own code group
   always_comb begin
      status_d = (state_d == SYNC_ACQUIRED) || (state_d == SYNC_ACQUIRED_A);
      sudi_d   = {pudi_i, rx_even_d};
   end

   assign code_sync_status_o = status_q;
   assign status_d_o         = status_d;
   assign sudi_o             = sudi_q;

endmodule

// File: rtl/pcs_sync_multilane.sv
// pcs_sync_multilane: LANES independent 1000BASE-X code-group synchronizers; PCS_SYNC_RD_CHECK_EN enables RD checking
module pcs_sync_multilane
   import pcs_sync_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int COMMA_CNT = 3,
   parameter int GOOD_CGS  = 3,
   parameter int LOSS_BAD  = 4
) (
   input  logic                    Clk,
   input  logic                    mr_main_reset_n,
   input  logic [LANES-1:0]        signal_detect,
   input  logic [PUDI_W*LANES-1:0] PUDI,
   output logic [LANES-1:0]        code_sync_status,
   output logic [SUDI_W*LANES-1:0] SUDI,
   output logic                    all_sync
);

   logic [1:0]       rst_sync_q;
   logic             rst_n;
   logic [LANES-1:0] status_d;
   logic             all_sync_q;

   // Reset asserts immediately and releases on a clock edge
   always_ff @(posedge Clk or negedge mr_main_reset_n)
      if (!mr_main_reset_n) rst_sync_q <= '0;
      else                  rst_sync_q <= {rst_sync_q[0], 1'b1};

   assign rst_n = rst_sync_q[1];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pcs_sync_lane #(
         .COMMA_CNT(COMMA_CNT),
         .GOOD_CGS (GOOD_CGS),
         .LOSS_BAD (LOSS_BAD)
      ) u_lane (
         .clk_i             (Clk),
         .rst_ni            (rst_n),
         .signal_detect_i   (signal_detect[i]),
         .pudi_i            (PUDI[PUDI_W*i +: PUDI_W]),
         .code_sync_status_o(code_sync_status[i]),
         .status_d_o        (status_d[i]),
         .sudi_o            (SUDI[SUDI_W*i +: SUDI_W])
      );
   end

   // Aggregate flag moves on the same edge as the lane status that changes it
   always_ff @(posedge Clk or negedge rst_n)
      if (!rst_n) all_sync_q <= 1'b0;
      else        all_sync_q <= &status_d;

   assign all_sync = all_sync_q;

endmodule

// File: tb/tb_pcs_sync_multilane.sv
// tb_pcs_sync_multilane: directed checks of acquisition, loss, lane independence, resets and RD handling
module tb_pcs_sync_multilane;

   localparam logic [9:0] KM  = 10'b0011111010;
   localparam logic [9:0] KP  = 10'b1100000101;
   localparam logic [9:0] D56 = 10'b1010010110;
   localparam logic [9:0] BAD = 10'b0000000000;
`ifdef PCS_SYNC_RD_CHECK_EN
   localparam logic [3:0] RD_EXP = 4'h0;
`else
   localparam logic [3:0] RD_EXP = 4'hF;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  sd;
   logic [39:0] pudi;
   logic [3:0]  status;
   logic [43:0] sudi;
   logic        all_sync;
   int          pass_n = 0;
   int          fail_n = 0;
   int          total_n = 0;
   logic [9:0]  acq [6];

   pcs_sync_multilane dut (
      .Clk             (clk),
      .mr_main_reset_n (rst_n),
      .signal_detect   (sd),
      .PUDI            (pudi),
      .code_sync_status(status),
      .SUDI            (sudi),
      .all_sync        (all_sync)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
      total_n++;
      assert (obs === exp) pass_n++;
      else begin
         fail_n++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [9:0] g0, input logic [9:0] g1, input logic [9:0] g2, input logic [9:0] g3);
      pudi = {g3, g2, g1, g0};
      @(posedge clk);
      #1;
   endtask

   task automatic put_all(input logic [9:0] g);
      put(g, g, g, g);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) put_all(D56);
   endtask

   task automatic acquire();
      for (int i = 0; i < 6; i++) put_all(acq[i]);
   endtask

   initial begin
      acq = '{KM, D56, KP, D56, KM, D56};
      rst_n = 1'b0;
      sd = 4'hF;
      pudi = {4{D56}};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_status", status, 4'h0);
      chk("reset_sudi", sudi, 44'h0);
      chk("reset_all_sync", all_sync, 1'b0);
      rst_n = 1'b1;
      repeat (4) put_all(D56);
      chk("idle_status", status, 4'h0);
      // acquisition: parity 1,0,1,0,1,0 and status rising on the 6th group
      for (int i = 0; i < 6; i++) begin
         put_all(acq[i]);
         chk("acq_sudi0", sudi[10:0], {acq[i], ~i[0]});
         chk("acq_status", status, (i == 5) ? 4'hF : 4'h0);
      end
      chk("acq_all_sync", all_sync, 1'b1);
      // four bads with too few goods between them
      put_all(BAD); chk("loss_1", status, 4'hF);
      put_all(D56); chk("loss_2", status, 4'hF);
      put_all(BAD); chk("loss_3", status, 4'hF);
      put_all(D56); chk("loss_4", status, 4'hF);
      put_all(BAD); chk("loss_5", status, 4'hF);
      put_all(D56); chk("loss_6", status, 4'hF);
      put_all(BAD); chk("loss_7", status, 4'h0);
      chk("loss_all_sync", all_sync, 1'b0);
      // re-acquire, then bads each cancelled by three goods
      acquire();
      chk("reacq_status", status, 4'hF);
      for (int i = 0; i < 4; i++) begin
         put_all(BAD);
         repeat (3) put_all(D56);
         chk("tolerate_status", status, 4'hF);
      end
      chk("tolerate_all_sync", all_sync, 1'b1);
      // lane 2 alone receives invalid groups
      repeat (3) put(D56, D56, BAD, D56);
      chk("indep_3_status", status, 4'hF);
      chk("indep_3_all_sync", all_sync, 1'b1);
      put(D56, D56, BAD, D56);
      chk("indep_4_status", status, 4'b1011);
      chk("indep_4_all_sync", all_sync, 1'b0);
      // loss of signal on lane 1
      sd = 4'b1101;
      put_all(D56);
      chk("sigdet_status", status, 4'b1001);
      sd = 4'hF;
      // asynchronous reset between edges
      put_all(D56);
      #2 rst_n = 1'b0;
      #1;
      chk("async_status", status, 4'h0);
      chk("async_sudi", sudi, 44'h0);
      chk("async_all_sync", all_sync, 1'b0);
      // comma in the wrong parity slot while acquiring
      do_reset();
      put_all(KM);
      put_all(D56);
      put_all(D56);
      put_all(KP);
      chk("odd_comma_sudi0", sudi[10:0], {KP, 1'b0});
      put_all(D56);
      put_all(KM);
      put_all(D56);
      chk("odd_comma_status", status, 4'h0);
      // same-disparity commas: bad only when disparity is checked
      do_reset();
      acquire();
      chk("rd_acq_status", status, 4'hF);
      put_all(KP);
      put_all(D56);
      put_all(KM);
      put_all(D56);
      put_all(KM);
      chk("rd_comma_status", status, 4'hF);
      repeat (3) put_all(BAD);
      chk("rd_bad_status", status, RD_EXP);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
